// File: rtl/operand_fetch.sv
// operand_fetch: decode / operand-fetch stage between instruction fetch and execute.
//   Two stages: S1 holds an accepted instruction while the register file (which
//   registers its read address) returns operands; OUT holds the registered bundle
//   presented to execute. Sustains one instruction per cycle when out_ready stays high.
// Ports:
//   clk, rst (sync, active-high), flush (sync squash of S1 and OUT)
//   in_valid/in_ready/in_instr/in_pc         : fetch handshake
//   rf_rs1_addr/rf_rs2_addr, rf_rs1_data/rf_rs2_data : register file read ports
//   wb_we/wb_rd_addr/wb_rd_data              : writeback (also drives the register file)
//   out_valid/out_ready, out_pc/out_instr/out_rs1_val/out_rs2_val/out_imm/out_rd_addr
// Configuration:
//   OF_WB_BYPASS_EN : when defined, a writeback landing on the operand capture edge
//                     is forwarded into the captured operand (never for x0).
module operand_fetch #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic [RADDR_W-1:0] rf_rs1_addr,
  output logic [RADDR_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]    rf_rs1_data,
  input  logic [XLEN-1:0]    rf_rs2_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_rs1_val,
  output logic [XLEN-1:0]    out_rs2_val,
  output logic [XLEN-1:0]    out_imm,
  output logic [RADDR_W-1:0] out_rd_addr
);

  logic               s1_valid;
  logic [XLEN-1:0]    s1_instr;
  logic [XLEN-1:0]    s1_pc;
  logic               s1_move;
  logic               accept;
  logic [RADDR_W-1:0] s1_rs1;
  logic [RADDR_W-1:0] s1_rs2;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    s1_imm;

  assign s1_move  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~rst & ~flush & (~s1_valid | s1_move);
  assign accept   = in_valid & in_ready;

  assign s1_rs1 = RADDR_W'(s1_instr[19:15]);
  assign s1_rs2 = RADDR_W'(s1_instr[24:20]);

  // A stalled S1 keeps its own addresses on the register file so the
  // registered read data still belongs to it when it finally moves.
  always_comb begin
    rf_rs1_addr = RADDR_W'(in_instr[19:15]);
    rf_rs2_addr = RADDR_W'(in_instr[24:20]);
    if (s1_valid && !s1_move) begin
      rf_rs1_addr = s1_rs1;
      rf_rs2_addr = s1_rs2;
    end
  end

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i);
    logic signed [31:0] imm32;
    imm32 = '0;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm32 = {{20{i[31]}}, i[31:20]};
      7'b0100011: imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: imm32 = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm32 = {i[31:12], 12'b0};
      7'b1101111: imm32 = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  assign s1_imm = gen_imm(s1_instr[31:0]);

`ifdef OF_WB_BYPASS_EN
  // The register file sampled its data before this edge's write; forward it.
  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
    if (wb_we && (wb_rd_addr != '0) && (wb_rd_addr == s1_rs1)) rs1_val = wb_rd_data;
    if (wb_we && (wb_rd_addr != '0) && (wb_rd_addr == s1_rs2)) rs2_val = wb_rd_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd_addr, wb_rd_data};
  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_instr    <= '0;
      s1_pc       <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd_addr <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_instr <= in_instr;
        s1_pc    <= in_pc;
        s1_valid <= 1'b1;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (s1_move) begin
        out_valid   <= 1'b1;
        out_pc      <= s1_pc;
        out_instr   <= s1_instr;
        out_rs1_val <= rs1_val;
        out_rs2_val <= rs2_val;
        out_imm     <= s1_imm;
        out_rd_addr <= RADDR_W'(s1_instr[11:7]);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, wb_we, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_rs1_data, rf_rs2_data, wb_rd_data;
  logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, wb_rd_addr, out_rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc, instr, rs1, rs2, imm;
    logic [4:0]  rd;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_rd_addr(out_rd_addr)
  );

  // Register file model: registered read address, write on the clock edge.
  logic [31:0] mem [32];
  logic [4:0]  ra1, ra2;
  always @(posedge clk) begin
    ra1 <= rf_rs1_addr;
    ra2 <= rf_rs2_addr;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i) * 32'h11;
    end else if (wb_we && wb_rd_addr != 5'd0) begin
      mem[wb_rd_addr] <= wb_rd_data;
    end
  end
  assign rf_rs1_data = mem[ra1];
  assign rf_rs2_data = mem[ra2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm);
    exp_t e;
    logic [4:0] a1, a2;
    a1 = instr[19:15];
    a2 = instr[24:20];
    e.pc = pc; e.instr = instr; e.imm = imm; e.rd = instr[11:7];
    e.rs1 = mem[a1];
    e.rs2 = mem[a2];
    return e;
  endfunction

  // Monitor: every transfer to execute must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got pc %h with empty scoreboard", out_pc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_rs1_val", out_rs1_val, e.rs1);
        chk("out_rs2_val", out_rs2_val, e.rs2);
        chk("out_imm", out_imm, e.imm);
        chk("out_rd_addr", 32'(out_rd_addr), 32'(e.rd));
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                      input bit push);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sbq.push_back(mk(instr, pc, imm));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: pc %h not accepted in 50 cycles, required accept", pc);
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [11:0] v;
    exp_t e;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1; wb_we = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;

    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_rs1", out_rs1_val, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick(1);

    // 2: addi x5,x0,-1 latency
    send(32'hFFF00293, 32'h0000_0100, 32'hFFFFFFFF, 1'b1);
    @(negedge clk); chk("lat_cyc1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_cyc2_valid", 32'(out_valid), 32'd1);
    tick(3);

    // 3a: 8-instruction stream, out_ready held high
    v = '0;
    fork
      repeat (12) begin @(negedge clk); v = {v[10:0], out_valid}; end
      for (int k = 1; k <= 8; k++)
        send({12'(k), 5'(k), 3'b000, 5'(k), 7'h13}, 32'h1000 + 32'(k) * 4, 32'(k), 1'b1);
    join
    chk("stream_valid_run", 32'(v), 32'(12'b001111111100));
    tick(2);

    // 3b: stream with a 3-cycle out_ready stall
    fork
      for (int k = 9; k <= 16; k++)
        send({12'(k), 5'(k), 3'b000, 5'(k), 7'h13}, 32'h1000 + 32'(k) * 4, 32'(k), 1'b1);
      begin
        tick(4);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (c == 1) chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    tick(6);
    chk("stream_drained", 32'(sbq.size()), 32'd0);

    // 4: writeback on the capture edge, add x3,x1,x2 (x1=0x11, x2=0x22)
    e = mk(32'h002081B3, 32'h0000_0200, 32'd0);
`ifdef OF_WB_BYPASS_EN
    e.rs1 = 32'hAA;
`else
    e.rs1 = 32'h11;
`endif
    e.rs2 = 32'h22;
    sbq.push_back(e);
    send(32'h002081B3, 32'h0000_0200, 32'd0, 1'b0);
    wb_we = 1'b1; wb_rd_addr = 5'd1; wb_rd_data = 32'hAA;
    tick(1);
    wb_we = 1'b0;
    tick(3);
    // writeback to x0 must never reach the operand: add x3,x0,x2
    e = mk(32'h002001B3, 32'h0000_0204, 32'd0);
    e.rs1 = 32'h0;
    sbq.push_back(e);
    send(32'h002001B3, 32'h0000_0204, 32'd0, 1'b0);
    wb_we = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'hBB;
    tick(1);
    wb_we = 1'b0;
    tick(3);
    chk("bypass_drained", 32'(sbq.size()), 32'd0);

    // 5: flush with S1 and OUT both occupied
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_0300, 32'd1, 1'b0);
    send(32'h00200113, 32'h0000_0304, 32'd2, 1'b0);
    tick(1);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h0000_0308;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flush_no_emit", 32'(out_valid), 32'd0);
    end
    tick(1);

    // 6: immediate formats
    send(32'hFE112E23, 32'h0000_0400, 32'hFFFFFFFC, 1'b1);
    send(32'hFE000EE3, 32'h0000_0404, 32'hFFFFFFFC, 1'b1);
    send(32'h12345037, 32'h0000_0408, 32'h12345000, 1'b1);
    send(32'h0080006F, 32'h0000_040C, 32'h00000008, 1'b1);
    send(32'h002081B3, 32'h0000_0410, 32'h00000000, 1'b1);
    tick(6);
    chk("final_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
